// File: rtl/i3c_mem_port_arbiter_pkg.sv
// Shared types and constants for the DAT/DCT table memory port arbiter.
//   DatAw            : default DAT word address width
//   I3CMemArbStarveW : width of the starvation counter
//   mem_arb_src_e    : which requester owns an in-flight read
//   starve_next()    : saturating update of the starvation counter
package i3c_mem_port_arbiter_pkg;

  localparam int DatAw            = 7;
  localparam int I3CMemArbStarveW = 4;

  typedef enum logic {
    ARB_SRC_A = 1'b0,
    ARB_SRC_B = 1'b1
  } mem_arb_src_e;

  // Counts consecutive denied cycles of A; any grant or idle cycle restarts it.
  function automatic logic [I3CMemArbStarveW-1:0] starve_next(
    input logic [I3CMemArbStarveW-1:0] q,
    input logic [I3CMemArbStarveW-1:0] limit,
    input logic                        a_req,
    input logic                        a_gnt
  );
    if (!a_req || a_gnt) return '0;
    if (q >= limit)      return q;
    return q + 1'b1;
  endfunction

endpackage

// File: rtl/i3c_mem_port_arbiter_if.sv
// One requester's table-memory port.
//   master : requester side (drives req/write/addr/wdata/wmask)
//   slave  : arbiter side   (drives gnt/rvalid/rdata)
interface i3c_mem_port_arbiter_if #(
  parameter int AddrWidth = i3c_mem_port_arbiter_pkg::DatAw,
  parameter int DataWidth = 64,
  parameter int MaskWidth = DataWidth
) ();
  logic                 req;
  logic                 write;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wdata;
  logic [MaskWidth-1:0] wmask;
  logic                 gnt;
  logic                 rvalid;
  logic [DataWidth-1:0] rdata;

  modport master (output req, write, addr, wdata, wmask, input gnt, rvalid, rdata);
  modport slave  (input req, write, addr, wdata, wmask, output gnt, rvalid, rdata);
endinterface

// File: rtl/i3c_mem_arb_rsp_pipe.sv
// Read response steering. Remembers who issued the read granted this cycle
// and routes the RAM data (1-cycle latency) back to that requester only.
//   rd_gnt_i / rd_src_i : a read was granted this cycle, and to whom
//   mem_rdata_i         : RAM read data
//   a_* / b_*           : per-requester rvalid pulse and gated rdata
module i3c_mem_arb_rsp_pipe
  import i3c_mem_port_arbiter_pkg::*;
#(
  parameter int DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rd_gnt_i,
  input  mem_arb_src_e         rd_src_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic                 a_rvalid_o,
  output logic [DataWidth-1:0] a_rdata_o,
  output logic                 b_rvalid_o,
  output logic [DataWidth-1:0] b_rdata_o
);

  logic         rsp_pend_q;
  mem_arb_src_e rsp_src_q;

  // Async reset drops any in-flight read, so no rvalid appears after release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_pend_q <= 1'b0;
      rsp_src_q  <= ARB_SRC_A;
    end else begin
      rsp_pend_q <= rd_gnt_i;
      if (rd_gnt_i) rsp_src_q <= rd_src_i;
    end
  end

  always_comb begin
    a_rvalid_o = rsp_pend_q && (rsp_src_q == ARB_SRC_A);
    b_rvalid_o = rsp_pend_q && (rsp_src_q == ARB_SRC_B);
    a_rdata_o  = a_rvalid_o ? mem_rdata_i : '0;
    b_rdata_o  = b_rvalid_o ? mem_rdata_i : '0;
  end

endmodule

// File: rtl/i3c_mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port DAT/DCT table RAM.
// B (command engine) has fixed priority; A (CSR window) takes priority once
// it has been denied StarveLimit (1..15) consecutive cycles.
// Optional: define I3C_MEM_ARB_LOCK_EN to add b_lock_i, which keeps A out
// while B is the last grantee so B read-modify-write sequences are atomic.
//   clk_i, rst_i  : clock, async active-high reset
//   a, b          : requester ports (slave side of the port interface)
//   b_lock_i      : (lock build only) B atomic-sequence lock
//   mem_*         : RAM request side; mem_rdata_i valid 1 cycle after a read
module i3c_mem_port_arbiter
  import i3c_mem_port_arbiter_pkg::*;
#(
  parameter int AddrWidth   = DatAw,
  parameter int DataWidth   = 64,
  parameter int MaskWidth   = DataWidth,
  parameter int StarveLimit = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  i3c_mem_port_arbiter_if.slave a,
  i3c_mem_port_arbiter_if.slave b,
`ifdef I3C_MEM_ARB_LOCK_EN
  input  logic                 b_lock_i,
`endif
  output logic                 mem_req_o,
  output logic                 mem_write_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [MaskWidth-1:0] mem_wmask_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  // Field order matches the dat/dct memory sink request.
  typedef struct packed {
    logic                 write;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [MaskWidth-1:0] wmask;
  } mem_req_t;

  localparam logic [I3CMemArbStarveW-1:0] Limit = I3CMemArbStarveW'(StarveLimit);

  logic [I3CMemArbStarveW-1:0] starve_q;
  logic     a_win, b_win, a_block;
  mem_req_t sel;

`ifdef I3C_MEM_ARB_LOCK_EN
  logic last_b_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      last_b_q <= 1'b0;
    else if (a_win) last_b_q <= 1'b0;
    else if (b_win) last_b_q <= 1'b1;
  end

  assign a_block = b_lock_i && last_b_q;
`else
  assign a_block = 1'b0;
`endif

  // Grants are gated by rst_i so requests held during reset are never taken.
  always_comb begin
    a_win = !rst_i && a.req && !a_block && (!b.req || (starve_q >= Limit));
    b_win = !rst_i && b.req && !a_win;
    a.gnt = a_win;
    b.gnt = b_win;

    sel = '0;
    if (a_win)      sel = '{write: a.write, addr: a.addr, wdata: a.wdata, wmask: a.wmask};
    else if (b_win) sel = '{write: b.write, addr: b.addr, wdata: b.wdata, wmask: b.wmask};

    mem_req_o   = a_win | b_win;
    mem_write_o = sel.write;
    mem_addr_o  = sel.addr;
    mem_wdata_o = sel.wdata;
    mem_wmask_o = sel.wmask;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) starve_q <= '0;
    else       starve_q <= starve_next(starve_q, Limit, a.req, a_win);
  end

  i3c_mem_arb_rsp_pipe #(.DataWidth(DataWidth)) u_rsp_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_gnt_i    ((a_win && !a.write) || (b_win && !b.write)),
    .rd_src_i    (a_win ? ARB_SRC_A : ARB_SRC_B),
    .mem_rdata_i (mem_rdata_i),
    .a_rvalid_o  (a.rvalid),
    .a_rdata_o   (a.rdata),
    .b_rvalid_o  (b.rvalid),
    .b_rdata_o   (b.rdata)
  );

endmodule

// File: tb/tb_i3c_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// cycle by cycle against a transaction-level reference of the arbiter.
module tb_i3c_mem_port_arbiter;
  import i3c_mem_port_arbiter_pkg::*;

  localparam int AW = DatAw, DW = 64, MW = 64, LIM = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  i3c_mem_port_arbiter_if #(.AddrWidth(AW), .DataWidth(DW), .MaskWidth(MW)) a_if ();
  i3c_mem_port_arbiter_if #(.AddrWidth(AW), .DataWidth(DW), .MaskWidth(MW)) b_if ();

  logic          b_lock;
  logic          mem_req, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  i3c_mem_port_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MaskWidth(MW), .StarveLimit(LIM)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .a           (a_if),
    .b           (b_if),
`ifdef I3C_MEM_ARB_LOCK_EN
    .b_lock_i    (b_lock),
`endif
    .mem_req_o   (mem_req),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_wmask_o (mem_wmask),
    .mem_rdata_i (mem_rdata)
  );

  // Table RAM: single port, 1-cycle read latency, bit-masked writes.
  logic [DW-1:0] ram [DEPTH];
  always_ff @(posedge clk) begin
    if (mem_req && mem_write)
      ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    else if (mem_req)
      mem_rdata <= ram[mem_addr];
  end

  // Reference model state: memory image, denial count, expected response.
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_den;
  bit            m_pend, m_src_b, m_last_b;
  logic [DW-1:0] m_data;
  bit            act_ga, act_gb;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_a(input bit req, input bit wr, input int addr, input logic [DW-1:0] wd,
                       input logic [MW-1:0] wm);
    a_if.req = req; a_if.write = wr; a_if.addr = AW'(addr); a_if.wdata = wd; a_if.wmask = wm;
  endtask

  task automatic set_b(input bit req, input bit wr, input int addr, input logic [DW-1:0] wd,
                       input logic [MW-1:0] wm);
    b_if.req = req; b_if.write = wr; b_if.addr = AW'(addr); b_if.wdata = wd; b_if.wmask = wm;
  endtask

  // One clock cycle: check at negedge against the model, advance the model,
  // then return 1 time unit after the posedge so the caller can drive inputs.
  task automatic step();
    bit ea, eb, blk;
    @(negedge clk);
    if (rst) begin m_pend = 0; m_den = 0; m_last_b = 0; end
    blk = b_lock && m_last_b;
    ea  = !rst && a_if.req && !blk && (!b_if.req || m_den >= LIM);
    eb  = !rst && b_if.req && !ea;

    chk("a_gnt", 128'(a_if.gnt), 128'(ea));
    chk("b_gnt", 128'(b_if.gnt), 128'(eb));
    chk("mem_req", 128'(mem_req), 128'(ea || eb));
    chk("mem_write", 128'(mem_write), ea ? 128'(a_if.write) : eb ? 128'(b_if.write) : 128'(0));
    chk("mem_addr", 128'(mem_addr), ea ? 128'(a_if.addr) : eb ? 128'(b_if.addr) : 128'(0));
    chk("mem_wdata", 128'(mem_wdata), ea ? 128'(a_if.wdata) : eb ? 128'(b_if.wdata) : 128'(0));
    chk("mem_wmask", 128'(mem_wmask), ea ? 128'(a_if.wmask) : eb ? 128'(b_if.wmask) : 128'(0));
    chk("a_rvalid", 128'(a_if.rvalid), 128'(m_pend && !m_src_b));
    chk("b_rvalid", 128'(b_if.rvalid), 128'(m_pend && m_src_b));
    chk("a_rdata", 128'(a_if.rdata), (m_pend && !m_src_b) ? 128'(m_data) : 128'(0));
    chk("b_rdata", 128'(b_if.rdata), (m_pend && m_src_b) ? 128'(m_data) : 128'(0));
    act_ga = a_if.gnt;
    act_gb = b_if.gnt;

    m_pend  = (ea && !a_if.write) || (eb && !b_if.write);
    m_src_b = eb;
    if (ea) m_data = ref_mem[a_if.addr];
    if (eb) m_data = ref_mem[b_if.addr];
    if (ea && a_if.write)
      ref_mem[a_if.addr] = (ref_mem[a_if.addr] & ~a_if.wmask) | (a_if.wdata & a_if.wmask);
    if (eb && b_if.write)
      ref_mem[b_if.addr] = (ref_mem[b_if.addr] & ~b_if.wmask) | (b_if.wdata & b_if.wmask);
    m_den = (!rst && a_if.req && !ea) ? ((m_den + 1 > LIM) ? LIM : m_den + 1) : 0;
    if (ea) m_last_b = 0;
    if (eb) m_last_b = 1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int first_a;
    logic [DW-1:0] old;
    for (int i = 0; i < DEPTH; i++) begin
      old = rnd64();
      ram[i] = old;
      ref_mem[i] = old;
    end
    b_lock = 1'b0;
    m_den = 0; m_pend = 0; m_src_b = 0; m_last_b = 0; m_data = '0;

    // Reset with both requesters asserting: nothing granted, all outputs 0.
    rst = 1'b1;
    set_a(1, 0, 3, '0, '0);
    set_b(1, 1, 4, rnd64(), '1);
    step(); step();
    rst = 1'b0;
    set_a(0, 0, 0, '0, '0); set_b(0, 0, 0, '0, '0);
    step();

    // A reads 0x05 alone.
    set_a(1, 0, 5, '0, '0);
    step();
    set_a(0, 0, 0, '0, '0);
    step();

    // Continuous contention: B wins LIM cycles, then A.
    set_a(1, 0, 6, '0, '0);
    set_b(1, 0, 7, '0, '0);
    first_a = -1;
    for (int i = 0; i < LIM + 2; i++) begin
      step();
      if (act_ga && first_a < 0) first_a = i;
      if (act_ga) set_a(0, 0, 0, '0, '0);
    end
    chk("starve_first_a", 128'(first_a), 128'(LIM));
    set_b(0, 0, 0, '0, '0);
    step(); step();

    // Masked B write then immediate A read of the same word.
    old = ref_mem[16];
    set_b(1, 1, 16, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF);
    step();
    set_b(0, 0, 0, '0, '0);
    set_a(1, 0, 16, '0, '0);
    step();
    set_a(0, 0, 0, '0, '0);
    chk("raw_rdata", 128'(a_if.rdata), 128'({old[63:32], 32'h0000_0001}));
    step();

    // Alternating A/B reads every cycle.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin set_a(1, 0, 1, '0, '0); set_b(0, 0, 0, '0, '0); end
      else            begin set_a(0, 0, 0, '0, '0); set_b(1, 0, 2, '0, '0); end
      step();
    end
    set_a(0, 0, 0, '0, '0); set_b(0, 0, 0, '0, '0);
    step();

    // Reset right after an A read grant: the response is dropped.
    set_a(1, 0, 3, '0, '0);
    step();
    rst = 1'b1;
    set_b(1, 0, 9, '0, '0);
    step(); step();
    rst = 1'b0;
    set_a(0, 0, 0, '0, '0); set_b(0, 0, 0, '0, '0);
    step();
    chk("no_rvalid_after_rst", 128'(a_if.rvalid), 128'(0));

`ifdef I3C_MEM_ARB_LOCK_EN
    // B locks for 8 cycles; A stays denied, then wins once lock drops.
    b_lock = 1'b1;
    set_b(1, 0, 2, '0, '0);
    step();
    set_b(0, 0, 0, '0, '0);
    set_a(1, 0, 4, '0, '0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("lock_a_denied", 128'(act_ga), 128'(0));
    end
    b_lock = 1'b0;
    step();
    chk("lock_release_a", 128'(act_ga), 128'(1));
    set_a(0, 0, 0, '0, '0);
    step();
`endif

    // Random traffic: requesters hold until granted, occasionally withdraw.
    for (int i = 0; i < 600; i++) begin
      if (!(a_if.req && !act_ga && ($urandom_range(0, 7) != 0)))
        set_a($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
              rnd64(), rnd64());
      if (!(b_if.req && !act_gb && ($urandom_range(0, 7) != 0)))
        set_b($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
              rnd64(), rnd64());
      step();
    end
    set_a(0, 0, 0, '0, '0); set_b(0, 0, 0, '0, '0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i3c_mem_port_arbiter.md
Name: i3c_mem_port_arbiter

Overview:
- Shares one single-port DAT or DCT table RAM (1-cycle read latency) between two requesters.
- Port A: software CSR window, the host-visible DAT/DCT access path.
- Port B: the controller command engine (address assignment, CCC sequencing).
- Fixed priority to B, with a starvation guard for A.
- Routes each read response back to the requester that issued it.
- One instance sits between each requester pair and its table memory, on the memory side of the I3C core.

Parameters:
- AddrWidth, default i3c_pkg::DatAw; RAM word address width.
- DataWidth, default 64; RAM word width (128 for the DCT instance).
- MaskWidth, default DataWidth; write bit-mask width.
- StarveLimit, default 4; consecutive cycles A may be denied before it takes priority. Legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- a_req_i  in  1  A request
- a_write_i  in  1  A write (1) / read (0)
- a_addr_i  in  AddrWidth  A word address
- a_wdata_i  in  DataWidth  A write data
- a_wmask_i  in  MaskWidth  A bit mask
- a_gnt_o  out  1  A accepted this cycle
- a_rvalid_o  out  1  A read data valid
- a_rdata_o  out  DataWidth  A read data
- b_req_i, b_write_i, b_addr_i, b_wdata_i, b_wmask_i, b_gnt_o, b_rvalid_o, b_rdata_o: same as the A set, for B
- mem_req_o  out  1  RAM request
- mem_write_o  out  1  RAM write
- mem_addr_o  out  AddrWidth  RAM address
- mem_wdata_o  out  DataWidth  RAM write data
- mem_wmask_o  out  MaskWidth  RAM mask
- mem_rdata_i  in  DataWidth  RAM read data, valid 1 cycle after a read request

Behaviour:
- Clock and reset:
  - Single clock domain, clk_i.
  - rst_i is asynchronous and active-high.
- Grant is combinational in the request cycle.
  - A requester holds req and all attributes stable until it sees gnt.
  - Dropping req before gnt is legal (request withdrawn).
- Arbitration:
  - If only one requester asserts req, it wins.
  - If both assert req, B wins unless starve_q >= StarveLimit, in which case A wins.
  - At most one gnt per cycle.
- Starvation counter starve_q, 4 bits:
  - Increments, saturating at StarveLimit, each cycle a_req_i && !a_gnt_o.
  - Clears to 0 on a_gnt_o or when a_req_i is low.
- Memory side:
  - mem_req_o = a_gnt_o | b_gnt_o.
  - mem_write_o, mem_addr_o, mem_wdata_o and mem_wmask_o are muxed from the winner.
  - All mem_* outputs are forced to 0 when there is no grant.
- Response pipeline:
  - A granted read registers rsp_src_q (A/B) and rsp_pend_q = 1.
  - The next cycle raises exactly one of a_rvalid_o / b_rvalid_o for 1 cycle, with x_rdata_o = mem_rdata_i.
  - Both rdata outputs drive 0 when their rvalid is low.
  - A granted write produces no response; gnt completes it.
  - Back-to-back reads (including alternating A/B) sustain 1 access per cycle.
  - Response order equals grant order.
- Read-after-write to the same address in consecutive cycles returns the new data; the RAM is write-first at 1-cycle spacing, and the arbiter adds no forwarding.
- Reset values:
  - a_gnt_o = b_gnt_o = 0; a_rvalid_o = b_rvalid_o = 0; all rdata outputs 0.
  - mem_* outputs 0; starve_q = 0; rsp_pend_q = 0.
- Reset mid-operation: a pending read response is discarded and no rvalid is issued after rst_i deasserts.
- Requests asserted during reset are not granted; arbitration resumes in the first cycle after release.

Optional Feature:
- Macro: I3C_MEM_ARB_LOCK_EN.
- When defined:
  - Adds input b_lock_i (1 bit).
  - While b_lock_i is high and B was the last grantee, A is denied regardless of starve_q. This makes B read-modify-write sequences atomic.
  - starve_q still counts but saturates.
  - Lock releases the cycle b_lock_i falls; if starve_q >= StarveLimit at that point, A wins next contention.
- When undefined: the port is absent and arbitration is exactly as in Behaviour.

Decomposition:
- i3c_pkg holds:
  - typedef mem_arb_src_e (ARB_SRC_A, ARB_SRC_B).
  - Parameterised request typedef matching dat_mem_sink_t / dct_mem_sink_t field order.
  - Constant I3CMemArbStarveW = 4.
- One sub-module, i3c_mem_arb_rsp_pipe: rsp_src_q/rsp_pend_q tracking and rvalid/rdata steering.

Test Plan:
- Reset, then A read addr 0x05 alone -> a_gnt_o same cycle; next cycle a_rvalid_o=1, a_rdata_o = RAM[0x05]; b_rvalid_o stays 0.
- Both request continuously, StarveLimit=4 -> B granted 4 cycles; A granted on the 5th; starve_q returns to 0.
- B writes 0xDEADBEEF_00000001 to 0x10 with upper-half mask 0, then A reads 0x10 next cycle -> A receives the old upper 32 bits, new lower 32 bits.
- Alternating A read 0x01 / B read 0x02 every cycle -> rvalid pattern A,B,A,B one cycle after each grant, data never cross-routed.
- Assert rst_i the cycle after an A read grant -> no a_rvalid_o after release; all outputs 0 during reset.
- With I3C_MEM_ARB_LOCK_EN: B holds b_lock_i for 8 cycles while A requests -> A denied all 8; A granted the cycle after lock drops.
